// File: rtl/round_robin_encoder_pkg.sv
// Shared types and helpers for the round-robin encoder slice.
package round_robin_encoder_pkg;

    // Grant FSM: IDLE presents nothing, GRANT presents a latched index.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } rr_state_t;

    // Width of a binary index into a vector of w lines (at least one bit).
    function automatic int index_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/round_robin_encoder_rr_pick.sv
// Circular priority picker: first set bit of vector at or after start,
// wrapping past WIDTH-1 back to 0. Purely combinational.
module rr_pick
    import round_robin_encoder_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int IW = index_width(WIDTH)
) (
    input  logic [WIDTH-1:0] vector,
    input  logic [IW-1:0]    start,
    output logic             found,
    output logic [IW-1:0]    index
);

    // Scan offsets from farthest to nearest so the nearest hit wins.
    // The extra bit in pos lets start+offset exceed WIDTH before the
    // explicit wrap, which keeps non-power-of-two widths correct.
    always_comb begin
        logic [IW:0]   pos;
        logic [IW-1:0] sel;
        found = 1'b0;
        index = '0;
        pos   = '0;
        sel   = '0;
        for (int k = WIDTH - 1; k >= 0; k--) begin
            pos = {1'b0, start} + (IW + 1)'(k);
            if (pos >= (IW + 1)'(WIDTH)) begin
                pos = pos - (IW + 1)'(WIDTH);
            end
            sel = pos[IW-1:0];
            if (vector[sel]) begin
                found = 1'b1;
                index = sel;
            end
        end
    end

endmodule

// File: rtl/round_robin_encoder.sv
// Round-robin request encoder: latches one requester at a time, holds the
// grant until ack, then rotates priority to the line after the granted one.
module round_robin_encoder
    import round_robin_encoder_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int IW = index_width(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] req,
    input  logic             ack,
    output logic             valid,
    output logic [IW-1:0]    index,
    output logic [WIDTH-1:0] onehot
);

    rr_state_t        state_reg;
    logic [IW-1:0]    ptr_reg;
    logic [IW-1:0]    index_reg;
    logic             valid_reg;

    logic [WIDTH-1:0] masked_req;
    logic [IW-1:0]    after_index;
    logic             idle_found;
    logic [IW-1:0]    idle_index;
    logic             ack_found;
    logic [IW-1:0]    ack_index;

    // Line following the current grant, wrapped explicitly.
    assign after_index = (index_reg == IW'(WIDTH - 1)) ? '0 : index_reg + IW'(1);

    // Requests with the currently granted line removed; used for the
    // back-to-back handoff so a lone requester must go through IDLE.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_mask
            assign masked_req[gi] = req[gi] & (index_reg != IW'(gi));
        end
    endgenerate

    rr_pick #(.WIDTH(WIDTH)) u_pick_idle (
        .vector (req),
        .start  (ptr_reg),
        .found  (idle_found),
        .index  (idle_index)
    );

    rr_pick #(.WIDTH(WIDTH)) u_pick_ack (
        .vector (masked_req),
        .start  (after_index),
        .found  (ack_found),
        .index  (ack_index)
    );

    // Grant FSM with pointer rotation on ack; reset wins over everything.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
            valid_reg <= 1'b0;
            index_reg <= '0;
            ptr_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (idle_found) begin
                        index_reg <= idle_index;
                        state_reg <= GRANT;
                        valid_reg <= 1'b1;
                    end
                end
                GRANT: begin
                    if (ack) begin
                        ptr_reg <= after_index;
                        if (ack_found) begin
                            index_reg <= ack_index;
                        end else begin
                            state_reg <= IDLE;
                            valid_reg <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    valid_reg <= 1'b0;
                end
            endcase
        end
    end

    // Outputs come only from registers or a decode of them.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_onehot
            assign onehot[gi] = valid_reg & (index_reg == IW'(gi));
        end
    endgenerate

    assign valid = valid_reg;
    assign index = index_reg;

endmodule
